// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz VGA timing constants and shared colours.
// Used by vga_ctrl and by the picture-generation blocks that feed it.
package vga_timing_pkg;

  // Horizontal timing, in vga_clk cycles
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BACK  = 10'd40;
  localparam logic [9:0] H_LEFT  = 10'd8;
  localparam logic [9:0] H_VALID = 10'd640;
  localparam logic [9:0] H_RIGHT = 10'd8;
  localparam logic [9:0] H_FRONT = 10'd8;

  // Vertical timing, in lines
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd25;
  localparam logic [9:0] V_TOP    = 10'd8;
  localparam logic [9:0] V_VALID  = 10'd480;
  localparam logic [9:0] V_BOTTOM = 10'd8;
  localparam logic [9:0] V_FRONT  = 10'd2;

  // Derived: 800 clocks per line, 525 lines per frame
  localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

  // First active clock of a line (144) and first active line (35)
  localparam logic [9:0] H_ACT0 = H_SYNC + H_BACK + H_LEFT;
  localparam logic [9:0] V_ACT0 = V_SYNC + V_BACK + V_TOP;

  // RGB565 colours shared with the picture blocks
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GOLDEN = 16'hFEC0;

endpackage

// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 Hz VGA timing generator on the 25 MHz vga_clk domain.
// Requests pixels one clock ahead via pix_x/pix_y and gates the returned pix_data
// onto rgb during the active window.
// Optional: define VGA_CTRL_FRAME_CNT_EN to add frame_start / frame_cnt outputs.
module vga_ctrl
  import vga_timing_pkg::*;
(
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid
`ifdef VGA_CTRL_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_end;
  logic       h_valid;
  logic       v_valid;
  logic       h_req;
  logic       pix_data_req;

  assign h_end = (cnt_h == H_TOTAL - 10'd1);

  // Horizontal counter: free-running 0..H_TOTAL-1
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h <= 10'd0;
    end else if (h_end) begin
      cnt_h <= 10'd0;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // Vertical counter: advances at end of each line, wraps with cnt_h at frame end
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_v <= 10'd0;
    end else if (h_end) begin
      if (cnt_v == V_TOTAL - 10'd1) begin
        cnt_v <= 10'd0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end
  end

  // Output decode: syncs, active window, and request window one clock early
  always_comb begin
    hsync        = (cnt_h < H_SYNC);
    vsync        = (cnt_v < V_SYNC);
    h_valid      = (cnt_h >= H_ACT0) && (cnt_h < H_ACT0 + H_VALID);
    v_valid      = (cnt_v >= V_ACT0) && (cnt_v < V_ACT0 + V_VALID);
    h_req        = (cnt_h >= H_ACT0 - 10'd1) && (cnt_h < H_ACT0 + H_VALID - 10'd1);
    rgb_valid    = h_valid && v_valid;
    pix_data_req = h_req && v_valid;
    pix_x        = pix_data_req ? (cnt_h - (H_ACT0 - 10'd1)) : 10'h3FF;
    pix_y        = pix_data_req ? (cnt_v - V_ACT0) : 10'h3FF;
    rgb          = rgb_valid ? pix_data : BLACK;
  end

`ifdef VGA_CTRL_FRAME_CNT_EN
  assign frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);

  // Frame counter: counts frame_start pulses, wraps naturally at 16 bits
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_cnt <= 16'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
